// File: rtl/shift_frame_pkg.sv
// ---------------------------------------------------------------------------
// shift_frame_pkg
// Shared definitions for the shift_frame_tx serial framer.
//
// Contents:
//   DATA_W                - width of the parallel word taken from the
//                           upstream shift-register stage
//   FRAME_BITS_NO_PARITY  - start + data + stop bit count with no parity bit
//   state_e               - framer state encoding
//   frameBits()           - number of bit periods in one frame
//   evenParity()          - parity bit that makes the total count of ones even
// ---------------------------------------------------------------------------
package shift_frame_pkg;

   localparam int DATA_W = 4;

   localparam int FRAME_BITS_NO_PARITY = 2 + DATA_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // A frame is start + data + stop, plus one extra period when parity is on.
   function automatic int frameBits(input int parityEn);
      return FRAME_BITS_NO_PARITY + ((parityEn != 0) ? 1 : 0);
   endfunction

   // XOR of all data bits; appending it gives an even number of ones.
   function automatic logic evenParity(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/shift_frame_tx_bit_tick_gen.sv
// ---------------------------------------------------------------------------
// bit_tick_gen
// Bit-period timer for the serial framer. Counts clock cycles within one
// serial bit and raises tick in the last cycle of that bit, after which the
// count wraps to zero so the next bit starts with a fresh period.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles each serial bit is held (1..256)
// Ports:
//   clk  - clock, rising edge active
//   rst  - asynchronous active-high reset, clears the count
//   load - holds the count at zero (used while the framer is idle so the
//          start bit always begins on a clean period)
//   tick - high in the final cycle of the current bit period
// ---------------------------------------------------------------------------
module bit_tick_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick
);

   // With one cycle per bit the counter never moves, but keep a 1-bit
   // register so the widths stay legal.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tick = (count_q == LAST_COUNT);

   // The counter reloads at every bit boundary (tick) and is parked at zero
   // while load is held, so every bit lasts exactly CLKS_PER_BIT cycles.
   always_comb begin
      count_d = count_q + CW'(1);
      if (load || tick) begin
         count_d = '0;
      end
   end

   // Count register; reset clears it asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/shift_frame_tx.sv
// ---------------------------------------------------------------------------
// shift_frame_tx
// Serialises a 4-bit word into an idle-high frame:
//   start (0), data bits 0..3 LSB first, optional even parity, stop (1).
// Each bit is held for CLKS_PER_BIT clock cycles. A word is accepted with a
// valid/ready handshake and latched, so data_in may change freely afterwards.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (1..256)
//   PARITY_EN    - 1 inserts an even-parity bit, 0 omits it
// Ports:
//   clk      - clock, rising edge active
//   rst      - asynchronous active-high reset, aborts any frame in flight
//   data_in  - parallel word to send
//   in_valid - data_in holds a word to send
//   in_ready - block accepts a word this cycle (idle and out of reset)
//   tx_out   - serial line, idle high
//   busy     - high while a frame is on the line
//   done     - one-cycle pulse in the first idle cycle after a stop bit
// ---------------------------------------------------------------------------
module shift_frame_tx
   import shift_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] LAST_BIT_IDX = 2'(DATA_W - 1);

   state_e            state_q;
   state_e            state_d;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] hold_d;
   logic [1:0]        bitIdx_q;
   logic [1:0]        bitIdx_d;
   logic              done_q;
   logic              done_d;

   logic              tick;
   logic              tickLoad;
   logic              accept;

   // Ready only in IDLE and never while reset is held, so nothing can be
   // latched during reset and the first accept is possible right after it.
   assign in_ready = (state_q == ST_IDLE) && !rst;
   assign accept   = in_ready && in_valid;

   // Keep the bit timer parked at zero while idle; the start bit then gets a
   // full period beginning in the cycle right after the accept edge.
   assign tickLoad = (state_q == ST_IDLE);

   bit_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bitTick (
      .clk  (clk),
      .rst  (rst),
      .load (tickLoad),
      .tick (tick)
   );

   // Next-state logic. Every non-idle state waits for tick so each bit is
   // held exactly one bit period. The STOP->IDLE move arms the done pulse,
   // which therefore appears in the first IDLE cycle; that cycle is also
   // ready, so a waiting word goes out with no extra idle gap.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      bitIdx_d = bitIdx_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               hold_d   = data_in;
               bitIdx_d = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               bitIdx_d = '0;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bitIdx_q == LAST_BIT_IDX) begin
                  bitIdx_d = '0;
                  state_d  = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 2'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            bitIdx_d = '0;
         end
      endcase
   end

   // State, holding register, bit index and done flag. Reset is
   // asynchronous so a frame in flight is dropped immediately, without a
   // done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hold_q   <= '0;
         bitIdx_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         bitIdx_q <= bitIdx_d;
         done_q   <= done_d;
      end
   end

   // Line driver, decoded straight from the registered state. Because reset
   // forces IDLE asynchronously, the line returns high as soon as rst rises.
   always_comb begin
      tx_out = 1'b1;
      case (state_q)
         ST_START:  tx_out = 1'b0;
         ST_DATA:   tx_out = hold_q[bitIdx_q];
         ST_PARITY: tx_out = evenParity(hold_q);
         default:   tx_out = 1'b1;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_shift_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_shift_frame_tx
// Directed bench for shift_frame_tx. Three instances cover the parameter
// sets of interest: A (4 clk/bit, parity), B (2 clk/bit, no parity) and
// C (1 clk/bit, parity). Inputs change on the falling edge; outputs are
// sampled on the falling edge as well, half a cycle away from the active
// edge. Expected frames are hand-written bit sequences, LSB = first bit.
// ---------------------------------------------------------------------------
module tb_shift_frame_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] inValid;
   logic [3:0] dataIn [3];
   wire  [2:0] inReady;
   wire  [2:0] txOut;
   wire  [2:0] busy;
   wire  [2:0] done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dutA (
      .clk(clk), .rst(rst), .data_in(dataIn[0]), .in_valid(inValid[0]),
      .in_ready(inReady[0]), .tx_out(txOut[0]), .busy(busy[0]), .done(done[0])
   );

   shift_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dutB (
      .clk(clk), .rst(rst), .data_in(dataIn[1]), .in_valid(inValid[1]),
      .in_ready(inReady[1]), .tx_out(txOut[1]), .busy(busy[1]), .done(done[1])
   );

   shift_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dutC (
      .clk(clk), .rst(rst), .data_in(dataIn[2]), .in_valid(inValid[2]),
      .in_ready(inReady[2]), .tx_out(txOut[2]), .busy(busy[2]), .done(done[2])
   );

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Called on a falling edge: offers a word, confirms it is acceptable,
   // lets the accept edge pass, then (unless told to keep it) withdraws
   // valid and scrambles data_in to show the latched copy is what gets sent.
   task automatic applyStimulus(input int inst, input logic [3:0] word,
                                input bit keepValid);
      inValid[inst] = 1'b1;
      dataIn[inst]  = word;
      checkOutput($sformatf("inst%0d ready before accept", inst), 8'(inReady[inst]), 8'd1);
      @(negedge clk);
      if (!keepValid) begin
         inValid[inst] = 1'b0;
         dataIn[inst]  = ~word;
      end
   endtask

   // Walks a frame cycle by cycle from the first cycle after the accept edge.
   // pulseAt >= 0 offers 4'hF for one cycle at that point (must be ignored);
   // stopAt >= 0 returns early at that cycle without checking it. A full run
   // ends on the done cycle with its checks made.
   task automatic checkFrame(input int inst, input int cpb, input int nBits,
                             input logic [6:0] expSeq, input int pulseAt,
                             input int stopAt, input string tag);
      for (int k = 0; k < nBits * cpb; k++) begin
         if (k == stopAt) return;
         if (pulseAt >= 0 && k == pulseAt) begin
            inValid[inst] = 1'b1;
            dataIn[inst]  = 4'hF;
         end else if (pulseAt >= 0 && k == pulseAt + 1) begin
            inValid[inst] = 1'b0;
         end
         checkOutput($sformatf("%s tx cyc%0d", tag, k), 8'(txOut[inst]), 8'(expSeq[k / cpb]));
         checkOutput($sformatf("%s busy cyc%0d", tag, k), 8'(busy[inst]), 8'd1);
         checkOutput($sformatf("%s done cyc%0d", tag, k), 8'(done[inst]), 8'd0);
         checkOutput($sformatf("%s ready cyc%0d", tag, k), 8'(inReady[inst]), 8'd0);
         @(negedge clk);
      end
      checkOutput($sformatf("%s done pulse", tag), 8'(done[inst]), 8'd1);
      checkOutput($sformatf("%s busy at done", tag), 8'(busy[inst]), 8'd0);
      checkOutput($sformatf("%s ready at done", tag), 8'(inReady[inst]), 8'd1);
      checkOutput($sformatf("%s tx at done", tag), 8'(txOut[inst]), 8'd1);
   endtask

   // Linear sequence of directed steps.
   initial begin
      rst     = 1'b1;
      inValid = '0;
      for (int i = 0; i < 3; i++) dataIn[i] = 4'h0;

      // Reset state of all three instances.
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("rst tx inst%0d", i), 8'(txOut[i]), 8'd1);
         checkOutput($sformatf("rst busy inst%0d", i), 8'(busy[i]), 8'd0);
         checkOutput($sformatf("rst done inst%0d", i), 8'(done[i]), 8'd0);
         checkOutput($sformatf("rst ready inst%0d", i), 8'(inReady[i]), 8'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("post-rst ready inst%0d", i), 8'(inReady[i]), 8'd1);

      // 4'b1011, 4 clk/bit, parity: 0,1,1,0,1,1,1; done 29th cycle.
      applyStimulus(0, 4'b1011, 1'b0);
      checkFrame(0, 4, 7, 7'b1110110, -1, -1, "t1011");
      @(negedge clk);
      checkOutput("t1011 done one cycle", 8'(done[0]), 8'd0);

      // 4'b0110, 2 clk/bit, no parity: 0,0,1,1,0,1; busy for 12 cycles.
      applyStimulus(1, 4'b0110, 1'b0);
      checkFrame(1, 2, 6, 7'b0101100, -1, -1, "t0110");
      @(negedge clk);
      checkOutput("t0110 done one cycle", 8'(done[1]), 8'd0);

      // Back to back: A (0,0,1,0,1,0,1) then 5 (0,1,0,1,0,0,1), valid held.
      applyStimulus(0, 4'hA, 1'b1);
      dataIn[0] = 4'h5;
      checkFrame(0, 4, 7, 7'b1010100, -1, -1, "tA");
      applyStimulus(0, 4'h5, 1'b0);
      checkFrame(0, 4, 7, 7'b1001010, -1, -1, "t5");
      @(negedge clk);
      checkOutput("t5 done one cycle", 8'(done[0]), 8'd0);

      // 4'h3 (0,1,1,0,0,0,1) with a stray 4'hF offered during DATA bit 1.
      applyStimulus(0, 4'h3, 1'b0);
      checkFrame(0, 4, 7, 7'b1000110, 10, -1, "t3pulse");
      @(negedge clk);
      checkOutput("t3pulse no extra frame", 8'(busy[0]), 8'd0);
      checkOutput("t3pulse done one cycle", 8'(done[0]), 8'd0);

      // 4'h9 aborted by reset in the middle of data bit 2 (cycle 13).
      applyStimulus(0, 4'h9, 1'b0);
      checkFrame(0, 4, 7, 7'b1010010, -1, 13, "t9");
      rst = 1'b1;
      #1;
      checkOutput("abort tx async", 8'(txOut[0]), 8'd1);
      checkOutput("abort busy", 8'(busy[0]), 8'd0);
      checkOutput("abort done", 8'(done[0]), 8'd0);
      checkOutput("abort ready in rst", 8'(inReady[0]), 8'd0);
      @(posedge clk);
      #1;
      checkOutput("abort held tx", 8'(txOut[0]), 8'd1);
      checkOutput("abort held done", 8'(done[0]), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort ready after rst", 8'(inReady[0]), 8'd1);
      checkOutput("abort no done after rst", 8'(done[0]), 8'd0);
      checkOutput("abort idle tx", 8'(txOut[0]), 8'd1);
      checkOutput("abort idle busy", 8'(busy[0]), 8'd0);

      // 4'h0, 1 clk/bit, parity: 0,0,0,0,0,0,1 on consecutive cycles.
      applyStimulus(2, 4'h0, 1'b0);
      checkFrame(2, 1, 7, 7'b1000000, -1, -1, "t0fast");
      @(negedge clk);
      checkOutput("t0fast done one cycle", 8'(done[2]), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_frame_tx.md
SHIFT_FRAME_TX -- requirements
Module: shift_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles each serial bit is held (legal range 1..256).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit after the data bits and 0 omits it.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port data_in, input, 4, the parallel word from the upstream 4-bit shift register stage.
REQ-006 SHALL have port in_valid, input, 1, meaning data_in holds a word to send.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port tx_out, output, 1, the serial line output (idle-high).
REQ-009 SHALL have port busy, output, 1, high while a frame is being transmitted.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at the end of each completed frame.

Function
REQ-011 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, latching data_in into an internal holding register.
REQ-012 SHALL drive in_ready=1 only in state IDLE with rst deasserted; in_valid in any other state is ignored and the word is not latched.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA; DATA->PARITY after bit 3 (or DATA->STOP when PARITY_EN=0); PARITY->STOP; STOP->IDLE.
REQ-014 SHALL advance from each bit to the next only after exactly CLKS_PER_BIT cycles, timed by a bit-period counter that reloads at every bit boundary.
REQ-015 SHALL drive tx_out=0 in START, latched bits LSB first (bit 0..3) in DATA, XOR of the 4 latched bits in PARITY, and 1 in STOP and IDLE.
REQ-016 SHALL start the START bit in the cycle immediately after the accept edge, so a frame lasts (6+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-017 SHALL assert busy in START, DATA, PARITY and STOP, and deassert it in IDLE.
REQ-018 SHALL pulse done for exactly one cycle, in the first IDLE cycle after a completed STOP bit; in_ready is also 1 in that cycle.
REQ-019 SHALL accept a new word in the done cycle when in_valid=1, giving back-to-back frames with no extra idle-high gap beyond the stop bit.
REQ-020 SHALL ignore changes on data_in after the accept edge; the transmitted frame uses only the latched word.
REQ-021 SHALL with CLKS_PER_BIT=1 send one bit per cycle and use the same state sequence.

Reset
REQ-022 SHALL while rst=1 force state=IDLE, tx_out=1, busy=0, done=0, in_ready=0, the holding register to 0, and both the bit-period and bit-index counters to 0.
REQ-023 SHALL on reset asserted mid-frame abort the frame immediately, with no done pulse, and return tx_out to 1 asynchronously.
REQ-024 SHALL raise in_ready in the first cycle after rst deasserts.

Structure
REQ-025 SHALL define the state enumeration, the frame-length constant and the data width (4) in shared package shift_frame_pkg.
REQ-026 SHALL place the bit-period counter in sub-module bit_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst, load; output tick).

Verification
REQ-027 SHALL test CLKS_PER_BIT=4, PARITY_EN=1, data_in=4'b1011 -> tx_out = 0,1,1,0,1,1,1, each held 4 cycles; done at cycle 29 after the accept edge.
REQ-028 SHALL test PARITY_EN=0, CLKS_PER_BIT=2, data_in=4'b0110 -> tx_out = 0,0,1,1,0,1, each held 2 cycles; 12-cycle frame; busy high for exactly 12 cycles.
REQ-029 SHALL test in_valid held high with words 4'hA then 4'h5 -> second accept lands in the done cycle; stop bit of A is followed directly by start bit of 5.
REQ-030 SHALL test in_valid pulsed with 4'hF during DATA -> no accept, in_ready=0, and the current frame is unchanged.
REQ-031 SHALL test rst asserted during bit 2 of 4'h9 -> tx_out=1 before the next clock edge, busy=0, no done, and in_ready=1 one cycle after rst release.
REQ-032 SHALL test CLKS_PER_BIT=1, data_in=4'h0 -> tx_out = 0,0,0,0,0,0,1 on consecutive cycles (parity 0).
